// File: rtl/name_pkg.sv
// Shared definitions for the record sequencer family: FSM encoding, default widths, header field offsets.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package name_pkg;

    localparam int DEF_OUT_W   = 128;
    localparam int DEF_CNT_W   = 32;
    localparam int DEF_IN_W    = DEF_OUT_W + DEF_CNT_W;
    localparam int DEF_MAX_LEN = 2**20;

    // A header word carries the record length at the bottom of the word;
    // a payload word carries the payload directly above the length field.
    localparam int LEN_LSB = 0;

    typedef enum logic {
        ST_HDR     = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;

endpackage

// File: rtl/name_out_reg.sv
// Single-entry output register with valid/ready handshake and a "last word" tag.
// Latency: 1 cycle from load to out_valid.
// Backpressure: holds out_data stable while out_valid && !out_ready; can_load tells the producer when a load is safe.
//
// Ports: load/load_data/load_last write a new word (only when can_load);
//        out_data/out_valid/out_ready is the downstream handshake;
//        last_xfer is high in the cycle a last-tagged word leaves the register.
module name_out_reg #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         load_last,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         can_load,
    output logic         last_xfer
);

    logic last_q;

    // Safe to load when empty, or when the held word leaves on this same edge.
    assign can_load  = !out_valid || out_ready;
    assign last_xfer = out_valid && out_ready && last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            last_q    <= 1'b0;
        end else if (load) begin
            out_data  <= load_data;
            out_valid <= 1'b1;
            last_q    <= load_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            last_q    <= 1'b0;
        end
    end

endmodule

// File: rtl/name_record_seq.sv
// Record sequencer: parses a length header, forwards N payload words, strobes rw once per completed record.
// Latency: payload word appears on out_data 1 cycle after acceptance; rw 1 cycle after the last word transfers.
// Backpressure: out_ready low stalls payload intake (in_ready drops); headers wait until the output register is empty.
//
// Ports: in_data/in_valid/in_ready  - header or payload words in
//        out_data/out_valid/out_ready - payload words out
//        rw - record-complete strobe, busy - inside a record,
//        rec_cnt - completed records (wrapping), err - sticky illegal-length flag
module name_record_seq
    import name_pkg::*;
#(
    parameter int IN_W    = DEF_IN_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int MAX_LEN = DEF_MAX_LEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             rw,
    output logic             busy,
    output logic [CNT_W-1:0] rec_cnt,
    output logic             err
);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic [CNT_W-1:0] hdr_len;
    logic [OUT_W-1:0] payload;
    logic             can_load;
    logic             last_xfer;
    logic             xfer;
    logic             hdr_acc;
    logic             pay_acc;
    logic             len_zero;
    logic             len_bad;
    logic             last_word;
    logic             rw_set;

    assign hdr_len = in_data[LEN_LSB +: CNT_W];
    assign payload = in_data[LEN_LSB + CNT_W +: OUT_W];

    // Headers need an empty output register so a zero-length record's rw can
    // never land on top of the previous record's rw. Held low during reset.
    assign in_ready = rst_n && ((state == ST_HDR) ? !out_valid : can_load);

    assign xfer     = in_valid && in_ready;
    assign hdr_acc  = xfer && (state == ST_HDR);
    assign pay_acc  = xfer && (state == ST_PAYLOAD);
    assign len_zero = (hdr_len == '0);
    assign len_bad  = 64'(hdr_len) > 64'(MAX_LEN);
    // Compare against <= 1 so a corrupted zero count still closes the record
    // instead of wrapping the counter.
    assign last_word = (cnt <= CNT_W'(1));

    // Only one source can fire per edge: a header is accepted only when the
    // output register is empty, so no last word can be leaving at that time.
    assign rw_set = last_xfer || (hdr_acc && len_zero && !len_bad);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_HDR;
            cnt     <= '0;
            rw      <= 1'b0;
            busy    <= 1'b0;
            rec_cnt <= '0;
            err     <= 1'b0;
        end else begin
            rw <= rw_set;
            if (rw_set) begin
                rec_cnt <= rec_cnt + CNT_W'(1);
            end

            case (state)
                ST_HDR: begin
                    if (hdr_acc) begin
                        if (len_bad) begin
                            err <= 1'b1;
                        end else if (!len_zero) begin
                            cnt   <= hdr_len;
                            state <= ST_PAYLOAD;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (pay_acc) begin
                        if (last_word) begin
                            cnt   <= '0;
                            state <= ST_HDR;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_HDR;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    name_out_reg #(
        .W(OUT_W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (pay_acc),
        .load_data (payload),
        .load_last (last_word),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .can_load  (can_load),
        .last_xfer (last_xfer)
    );

endmodule

// File: tb/tb_name_record_seq.sv
// Bench for name_record_seq: a default-width instance and a narrow CNT_W=4 instance share one
// transaction-level reference model (expected word queue, record phase, completion count).
// Stimulus is randomized: payloads, idle gaps on in_valid, out_ready back-pressure.
module tb_name_record_seq;

    localparam int S_MAX = 12;
    localparam int M_MAX = 2**20;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // bench-side drive
    logic         sel;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] pay;
    logic [31:0]  len;

    // main instance
    logic [159:0] m_in_data;
    logic         m_in_valid, m_in_ready, m_out_valid, m_rw, m_busy, m_err;
    logic [127:0] m_out_data;
    logic [31:0]  m_rec_cnt;

    // narrow instance
    logic [11:0]  s_in_data;
    logic         s_in_valid, s_in_ready, s_out_valid, s_rw, s_busy, s_err;
    logic [7:0]   s_out_data;
    logic [3:0]   s_rec_cnt;

    assign m_in_data  = {pay, len};
    assign m_in_valid = in_valid && !sel;
    assign s_in_data  = {pay[7:0], len[3:0]};
    assign s_in_valid = in_valid && sel;

    name_record_seq u_main (
        .clk(clk), .rst_n(rst_n),
        .in_data(m_in_data), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .out_data(m_out_data), .out_valid(m_out_valid), .out_ready(out_ready),
        .rw(m_rw), .busy(m_busy), .rec_cnt(m_rec_cnt), .err(m_err)
    );

    name_record_seq #(.IN_W(12), .OUT_W(8), .CNT_W(4), .MAX_LEN(S_MAX)) u_small (
        .clk(clk), .rst_n(rst_n),
        .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready),
        .rw(s_rw), .busy(s_busy), .rec_cnt(s_rec_cnt), .err(s_err)
    );

    // view of the instance under test
    logic         v_in_ready, v_out_valid, v_rw, v_busy, v_err;
    logic [127:0] v_out_data;
    logic [31:0]  v_rec_cnt;
    assign v_in_ready  = sel ? s_in_ready  : m_in_ready;
    assign v_out_valid = sel ? s_out_valid : m_out_valid;
    assign v_rw        = sel ? s_rw        : m_rw;
    assign v_busy      = sel ? s_busy      : m_busy;
    assign v_err       = sel ? s_err       : m_err;
    assign v_out_data  = sel ? {120'b0, s_out_data} : m_out_data;
    assign v_rec_cnt   = sel ? {28'b0, s_rec_cnt}   : m_rec_cnt;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference model: words that should be sitting in / passing through the output
    typedef struct {
        logic [127:0] d;
        bit           last;
    } word_t;

    word_t       q[$];
    bit          ph;        // inside a record's payload
    int          rem;       // payload words still expected for the record
    bit          m_errf;
    logic [31:0] m_rec;
    bit          accepted;
    int          gap_pct;

    function automatic longint max_len();
        return sel ? longint'(S_MAX) : longint'(M_MAX);
    endfunction

    function automatic logic [31:0] cnt_mask();
        return sel ? 32'hF : 32'hFFFF_FFFF;
    endfunction

    task automatic model_reset();
        q.delete();
        ph     = 0;
        rem    = 0;
        m_errf = 0;
        m_rec  = '0;
    endtask

    // One clock: predict from the current inputs, let the edge happen, compare.
    task automatic tick();
        bit          exp_rdy, ox, rwn;
        word_t       w;
        logic [31:0] n;
        #1;
        exp_rdy = ph ? (q.size() == 0 || out_ready) : (q.size() == 0);
        chk("in_ready", v_in_ready, exp_rdy);
        ox       = (q.size() != 0) && out_ready;
        rwn      = 0;
        accepted = in_valid && exp_rdy;
        if (ox) begin
            w   = q.pop_front();
            rwn = w.last;
        end
        if (accepted) begin
            if (!ph) begin
                n = len & cnt_mask();
                if (n == 0) rwn = 1;
                else if (longint'(n) > max_len()) m_errf = 1;
                else begin
                    ph  = 1;
                    rem = int'(n);
                end
            end else begin
                w.d    = sel ? {120'b0, pay[7:0]} : pay;
                w.last = (rem == 1);
                q.push_back(w);
                rem--;
                if (rem == 0) ph = 0;
            end
        end
        if (rwn) m_rec = (m_rec + 1) & cnt_mask();
        @(posedge clk);
        @(negedge clk);
        chk("out_valid", v_out_valid, q.size() != 0);
        if (q.size() != 0) chk("out_data", v_out_data, q[0].d);
        chk("rw", v_rw, rwn);
        chk("rec_cnt", v_rec_cnt, m_rec);
        chk("err", v_err, m_errf);
        chk("busy", v_busy, ph);
    endtask

    task automatic put_word(input logic [31:0] l, input logic [127:0] p, input int ordy);
        int tries;
        tries = 0;
        while (tries < 3 && $urandom_range(99) < gap_pct) begin
            in_valid  = 0;
            out_ready = ($urandom_range(99) < ordy);
            tick();
            tries++;
        end
        in_valid = 1;
        len      = l;
        pay      = p;
        tries    = 0;
        do begin
            out_ready = ($urandom_range(99) < ordy);
            tick();
            tries++;
        end while (!accepted && tries < 200);
        if (!accepted) chk("accept_timeout", 0, 1);
        in_valid = 0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Header of length n, then npay payload words (npay < n gives a partial record).
    task automatic send_record(input int n, input int npay, input int ordy);
        put_word(32'(n), rnd128(), ordy);
        if (n != 0 && longint'(n) <= max_len()) begin
            for (int i = 0; i < npay; i++) put_word($urandom, rnd128(), ordy);
        end
    endtask

    task automatic drain();
        in_valid  = 0;
        out_ready = 1;
        repeat (3) tick();
    endtask

    task automatic do_reset();
        rst_n    = 0;
        in_valid = 0;
        #1;
        chk("rst_out_valid", v_out_valid, 0);
        chk("rst_out_data", v_out_data, 0);
        chk("rst_rw", v_rw, 0);
        chk("rst_busy", v_busy, 0);
        chk("rst_rec_cnt", v_rec_cnt, 0);
        chk("rst_err", v_err, 0);
        chk("rst_in_ready", v_in_ready, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int r, n;
        rst_n = 0; sel = 0; in_valid = 0; out_ready = 0;
        pay = '0; len = '0; gap_pct = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // three-word record, no back-pressure
        send_record(3, 3, 100);
        drain();
        chk("rec_after_n3", v_rec_cnt, 1);

        // zero-length record
        send_record(0, 0, 100);
        drain();
        chk("rec_after_n0", v_rec_cnt, 2);

        // back-pressured record with input gaps
        gap_pct = 25;
        send_record(4, 4, 50);
        drain();
        chk("rec_after_n4", v_rec_cnt, 3);

        // illegal length, then a normal record
        send_record(M_MAX + 1, 0, 70);
        send_record(1, 1, 70);
        drain();
        chk("err_sticky", v_err, 1);
        chk("rec_after_err", v_rec_cnt, 4);

        // reset in the middle of a five-word record
        send_record(5, 2, 60);
        do_reset();
        send_record(2, 2, 60);
        drain();
        chk("rec_after_reset", v_rec_cnt, 1);

        // random records
        repeat (40) begin
            r = $urandom_range(9);
            n = (r == 9) ? M_MAX + 1 + int'($urandom_range(100)) : r;
            send_record(n, n, int'($urandom_range(30, 100)));
        end
        drain();

        // narrow build: count wrap, longest legal record, illegal length
        sel = 1;
        do_reset();
        repeat (15) begin
            n = int'($urandom_range(2));
            send_record(n, n, 70);
        end
        drain();
        chk("small_rec_15", v_rec_cnt, 15);
        send_record(1, 1, 70);
        drain();
        chk("small_rec_wrap", v_rec_cnt, 0);
        send_record(S_MAX, S_MAX, 70);
        drain();
        chk("small_rec_max_len", v_rec_cnt, 1);
        send_record(S_MAX + 1, 0, 70);
        drain();
        chk("small_err", v_err, 1);
        chk("small_rec_after_err", v_rec_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/name_record_seq.md
NAME_RECORD_SEQ -- requirements
Module: name_record_seq

Interface
REQ-001 Parameter IN_W, default 160, input word width; SHALL satisfy IN_W = OUT_W + CNT_W.
REQ-002 Parameter OUT_W, default 128, payload/output width.
REQ-003 Parameter CNT_W, default 32, record-length field width.
REQ-004 Parameter MAX_LEN, default 2**20, largest legal record length in payload words.
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 in_data  in  IN_W  header word (length in [CNT_W-1:0]) or payload word (payload in [IN_W-1:CNT_W]).
REQ-008 in_valid / in_ready  in / out  1 each  input handshake; a transfer occurs when both are high at a clock edge.
REQ-009 out_data  out  OUT_W  registered payload.
REQ-010 out_valid / out_ready  out / in  1 each  output handshake.
REQ-011 rw  out  1  one-cycle record-complete strobe.
REQ-012 busy  out  1  high while in PAYLOAD state.
REQ-013 rec_cnt  out  CNT_W  completed-record count; wraps to 0 after all-ones.
REQ-014 err  out  1  sticky illegal-length flag.

Function
REQ-015 The FSM SHALL have two states: HDR and PAYLOAD.
REQ-016 In HDR: in_ready = !out_valid; an accepted word is a header with length N = in_data[CNT_W-1:0].
REQ-017 For a header with N = 0: state stays HDR, rw pulses in the next cycle, and rec_cnt increments.
REQ-018 For a header with 1 <= N <= MAX_LEN: the counter loads N and the state moves to PAYLOAD.
REQ-019 For a header with N > MAX_LEN: the header is dropped, err sets, state stays HDR, and rw and rec_cnt are unchanged.
REQ-020 In PAYLOAD: in_ready = !out_valid || out_ready.
REQ-021 Each accepted payload word SHALL set out_data = in_data[IN_W-1:CNT_W] and out_valid = 1 on the same edge (latency 1), and decrement the counter.
REQ-022 Accepting a payload word while the counter = 1 SHALL mark that output word last and return the FSM to HDR.
REQ-023 out_valid SHALL clear on out_valid && out_ready unless a new word is loaded on the same edge.
REQ-024 rw SHALL pulse exactly one cycle, in the cycle after the last-marked word transfers on the output.
REQ-025 rec_cnt SHALL increment on that same edge as the rw pulse.
REQ-026 Output back-pressure SHALL never drop or duplicate a word; out_data SHALL be held stable while out_valid && !out_ready.
REQ-027 The counter SHALL never underflow.
REQ-028 rw SHALL never pulse twice in consecutive cycles for one record.
REQ-029 Because HDR requires an empty output register, N = 0 strobes SHALL never collide with the previous record's rw.
REQ-030 in_valid low mid-record SHALL stall the FSM without timeout.

Reset
REQ-031 rst_n low SHALL force, asynchronously: state = HDR, counter = 0, out_valid = 0, out_data = 0, rw = 0, busy = 0, rec_cnt = 0, err = 0.
REQ-032 Reset mid-record SHALL discard the partial record without an rw pulse.
REQ-033 Deassertion of rst_n SHALL be synchronised externally.
REQ-034 in_ready SHALL be 0 while rst_n is low.

Structure
REQ-035 The state encoding, default widths, and header-field offsets SHALL live in a shared package, name_pkg.
REQ-036 The output register and handshake SHALL be a sub-module, name_out_reg, reusable by sibling field blocks; the FSM and counter SHALL stay in the top module.

Verification
REQ-037 Header N=3, then payloads P0..P2 with out_ready=1 -> out_data P0, P1, P2 each 1 cycle after acceptance; rw pulses 1 cycle after P2 transfers; rec_cnt=1.
REQ-038 Header N=0 -> rw pulses the cycle after acceptance; out_valid stays 0; rec_cnt increments.
REQ-039 N=4 with out_ready toggling 1,0,0,1 -> no loss or duplication, out_data stable while stalled, exactly one rw.
REQ-040 Header N=MAX_LEN+1 -> err=1 and stays 1; the next header N=1 then completes normally with rw.
REQ-041 rst_n low after 2 of 5 payloads -> all outputs at reset values immediately; no rw; the next record works.
REQ-042 rec_cnt preset near all-ones via 2**CNT_W-1 completions (CNT_W=4 build), then one more -> wraps to 0.
